// File: rtl/sopc_timer_sequencer_pkg.sv
// sopc_timer_pkg: timer s1 register map, control bits, sequencer states
// and the {period, repeat} table entry layout.
package sopc_timer_pkg;

  localparam logic [2:0] A_STATUS  = 3'd0;
  localparam logic [2:0] A_CONTROL = 3'd1;
  localparam logic [2:0] A_PERIODL = 3'd2;
  localparam logic [2:0] A_PERIODH = 3'd3;

  localparam logic [3:0] CTL_ITO   = 4'b0001;
  localparam logic [3:0] CTL_CONT  = 4'b0010;
  localparam logic [3:0] CTL_START = 4'b0100;
  localparam logic [3:0] CTL_STOP  = 4'b1000;

  typedef enum logic [3:0] {
    S_IDLE,
    S_SCAN,
    S_WR_PL,
    S_WR_PH,
    S_WR_CTL,
    S_WAIT,
    S_WR_CLR,
    S_WAIT_LO,
    S_WR_STOP,
    S_WR_CLR2
  } state_e;

  typedef struct packed {
    logic [31:0] period;
    logic [7:0]  rpt;
  } slot_t;

endpackage

// File: rtl/sopc_timer_sequencer_if.sv
// Avalon-MM write-only link to the interval timer s1 port.
// master: address/chipselect/write_n/writedata out, irq in.
interface sopc_timer_sequencer_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic        irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output irq
  );
endinterface

// File: rtl/sopc_timer_seq_table.sv
// N_SLOTS x {period, repeat} register file.
// Ports: clk, reset_n, wr_en/wr_slot/wr_data write, rd_slot/rd_data comb read.
module sopc_timer_seq_table
  import sopc_timer_pkg::*;
#(
  parameter int N_SLOTS = 4,
  localparam int SW = $clog2(N_SLOTS)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          wr_en,
  input  logic [SW-1:0] wr_slot,
  input  slot_t         wr_data,
  input  logic [SW-1:0] rd_slot,
  output slot_t         rd_data
);

  slot_t mem [N_SLOTS];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_SLOTS; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_slot] <= wr_data;
    end
  end

  assign rd_data = mem[rd_slot];

endmodule

// File: rtl/sopc_timer_sequencer.sv
// Plays a {period, repeat} table on the interval timer as one-shot runs.
// Ports: clk, reset_n, cfg_* table write, go/abort, status/event pulses, tmr bus.
module sopc_timer_sequencer
  import sopc_timer_pkg::*;
#(
  parameter int N_SLOTS = 4,
  parameter bit LOOP    = 1'b0,
  localparam int SW = $clog2(N_SLOTS)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          cfg_wr,
  input  logic [SW-1:0] cfg_slot,
  input  logic [31:0]   cfg_period,
  input  logic [7:0]    cfg_repeat,
  input  logic          go,
  input  logic          abort,
  output logic          busy,
  output logic [SW-1:0] cur_slot,
  output logic          evt_pulse,
  output logic [SW-1:0] evt_slot,
  output logic          done_pulse,
  sopc_timer_sequencer_if.master tmr
);

  state_e        state_q, state_d;
  logic [SW-1:0] slot_q, slot_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [31:0]   per_q, per_d;
  logic          evt_d;
  slot_t         rd;

  logic          last;
  logic [SW-1:0] nxt_slot;
  state_e        nxt_state;

  logic          cs_q, cs_d;
  logic [2:0]    addr_q, addr_d;
  logic [15:0]   wd_q, wd_d;

  sopc_timer_seq_table #(.N_SLOTS(N_SLOTS)) u_table (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (cfg_wr),
    .wr_slot (cfg_slot),
    .wr_data ({cfg_period, cfg_repeat}),
    .rd_slot (slot_q),
    .rd_data (rd)
  );

  // Slot advance shared by SCAN skips and finished slots.
  assign last      = (slot_q == SW'(N_SLOTS - 1));
  assign nxt_slot  = last ? '0 : slot_q + 1'b1;
  assign nxt_state = (last && !LOOP) ? S_IDLE : S_SCAN;

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    cnt_d   = cnt_q;
    per_d   = per_q;
    evt_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (go && !abort) begin
          state_d = S_SCAN;
          slot_d  = '0;
        end
      end
      S_SCAN: begin
        if (rd.rpt == 8'd0) begin
          state_d = nxt_state;
          slot_d  = nxt_slot;
        end else begin
          cnt_d   = rd.rpt;
          per_d   = rd.period;
          state_d = S_WR_PL;
        end
      end
      S_WR_PL:  state_d = S_WR_PH;
      S_WR_PH:  state_d = S_WR_CTL;
      S_WR_CTL: state_d = S_WAIT;
      S_WAIT: begin
        if (tmr.irq) state_d = S_WR_CLR;
      end
      S_WR_CLR: state_d = S_WAIT_LO;
      S_WAIT_LO: begin
        evt_d = 1'b1;
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          state_d = nxt_state;
          slot_d  = nxt_slot;
        end else begin
          state_d = S_WR_CTL;
        end
      end
      S_WR_STOP: state_d = S_WR_CLR2;
      S_WR_CLR2: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    if (abort && !(state_q inside {S_IDLE, S_WR_STOP, S_WR_CLR2})) begin
      state_d = S_WR_STOP;
      slot_d  = slot_q;
      cnt_d   = cnt_q;
      evt_d   = 1'b0;
    end
  end

  // Bus cycle is decoded from the next state so the write
  // appears registered in the same cycle the state is entered.
  always_comb begin
    cs_d   = 1'b1;
    addr_d = A_STATUS;
    wd_d   = '0;
    unique case (state_d)
      S_WR_PL: begin
        addr_d = A_PERIODL;
        wd_d   = per_d[15:0];
      end
      S_WR_PH: begin
        addr_d = A_PERIODH;
        wd_d   = per_d[31:16];
      end
      S_WR_CTL: begin
        addr_d = A_CONTROL;
        wd_d   = {12'd0, CTL_START | CTL_ITO};
      end
      S_WR_STOP: begin
        addr_d = A_CONTROL;
        wd_d   = {12'd0, CTL_STOP};
      end
      S_WR_CLR, S_WR_CLR2: begin
        addr_d = A_STATUS;
      end
      default: cs_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      slot_q     <= '0;
      cnt_q      <= '0;
      per_q      <= '0;
      busy       <= 1'b0;
      cur_slot   <= '0;
      evt_pulse  <= 1'b0;
      evt_slot   <= '0;
      done_pulse <= 1'b0;
      cs_q       <= 1'b0;
      addr_q     <= '0;
      wd_q       <= '0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      cnt_q      <= cnt_d;
      per_q      <= per_d;
      busy       <= (state_d != S_IDLE);
      cur_slot   <= slot_d;
      evt_pulse  <= evt_d;
      if (evt_d) evt_slot <= slot_q;
      done_pulse <= (state_q != S_IDLE) && (state_d == S_IDLE);
      cs_q       <= cs_d;
      addr_q     <= addr_d;
      wd_q       <= wd_d;
    end
  end

  assign tmr.chipselect = cs_q;
  assign tmr.write_n    = ~cs_q;
  assign tmr.address    = addr_q;
  assign tmr.writedata  = wd_q;

endmodule

// File: tb/tb_sopc_timer_sequencer.sv
// Bench: two sequencers (LOOP=0/1) on behavioural timers,
// queue model of expected bus writes and events.
module tb_sopc_timer_sequencer;

  logic       clk;
  logic       reset_n;
  logic       cfg_wr;
  logic [1:0] cfg_slot;
  logic [31:0] cfg_period;
  logic [7:0] cfg_repeat;
  logic       go0, abort0, go1, abort1;
  logic       busy0, busy1, evt0, evt1, done0, done1;
  logic [1:0] cur0, cur1, evs0, evs1;

  sopc_timer_sequencer_if bus0 ();
  sopc_timer_sequencer_if bus1 ();

  sopc_timer_sequencer #(.N_SLOTS(4), .LOOP(1'b0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .cfg_wr(cfg_wr), .cfg_slot(cfg_slot),
    .cfg_period(cfg_period), .cfg_repeat(cfg_repeat), .go(go0),
    .abort(abort0), .busy(busy0), .cur_slot(cur0), .evt_pulse(evt0),
    .evt_slot(evs0), .done_pulse(done0), .tmr(bus0)
  );

  sopc_timer_sequencer #(.N_SLOTS(4), .LOOP(1'b1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .cfg_wr(cfg_wr), .cfg_slot(cfg_slot),
    .cfg_period(cfg_period), .cfg_repeat(cfg_repeat), .go(go1),
    .abort(abort1), .busy(busy1), .cur_slot(cur1), .evt_pulse(evt1),
    .evt_slot(evs1), .done_pulse(done1), .tmr(bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural interval timer, one per sequencer.
  logic [2:0]  ad [2];
  logic        cs [2];
  logic        wn [2];
  logic [15:0] wd [2];
  logic [31:0] t_per [2];
  logic [31:0] t_cnt [2];
  logic        t_to [2];
  logic        t_run [2];
  logic        t_ito [2];

  assign ad[0] = bus0.address;    assign ad[1] = bus1.address;
  assign cs[0] = bus0.chipselect; assign cs[1] = bus1.chipselect;
  assign wn[0] = bus0.write_n;    assign wn[1] = bus1.write_n;
  assign wd[0] = bus0.writedata;  assign wd[1] = bus1.writedata;
  assign bus0.irq = t_to[0] & t_ito[0];
  assign bus1.irq = t_to[1] & t_ito[1];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        t_per[i] <= '0; t_cnt[i] <= '0; t_to[i] <= 1'b0;
        t_run[i] <= 1'b0; t_ito[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (t_run[i]) begin
          if (t_cnt[i] == 0) begin
            t_to[i] <= 1'b1; t_run[i] <= 1'b0; t_cnt[i] <= t_per[i];
          end else begin
            t_cnt[i] <= t_cnt[i] - 1;
          end
        end
        if (cs[i] && !wn[i]) begin
          case (ad[i])
            3'd0: t_to[i] <= 1'b0;
            3'd1: begin
              t_ito[i] <= wd[i][0];
              if (wd[i][3]) t_run[i] <= 1'b0;
              else if (wd[i][2]) begin
                t_run[i] <= 1'b1; t_cnt[i] <= t_per[i];
              end
            end
            3'd2: t_per[i][15:0]  <= wd[i];
            3'd3: t_per[i][31:16] <= wd[i];
            default: ;
          endcase
        end
      end
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input bit ok, input string name,
                     input longint act, input longint exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Model of the table and expected traffic of instance 0.
  typedef struct { int a; int d; } wr_t;
  logic [31:0] m_per [4];
  logic [7:0]  m_rep [4];
  wr_t exq [$];
  int  evq [$];

  task automatic model_build();
    for (int s = 0; s < 4; s++) begin
      if (m_rep[s] != 0) begin
        exq.push_back('{2, int'(m_per[s][15:0])});
        exq.push_back('{3, int'(m_per[s][31:16])});
        for (int r = 0; r < int'(m_rep[s]); r++) begin
          exq.push_back('{1, 5});
          exq.push_back('{0, 0});
          evq.push_back(s);
        end
      end
    end
  endtask

  // Per-cycle compare for instance 0.
  int  n_wr0 = 0, n_ev0 = 0, n_done0 = 0, n_st0 = 0;
  int  go_cyc = 0, done_cyc = 0, start_cyc = 0, irq_cyc = 0;
  int  exp_lo = 0, exp_per = 0;
  bit  first_pend = 0, started = 0, irq_seen = 0, irq_prev = 0;
  wr_t e;
  int  es;

  always @(negedge clk) begin
    if (reset_n) begin
      chk(bus0.chipselect == !bus0.write_n, "cs_vs_write_n",
          bus0.chipselect, !bus0.write_n);
      if (bus0.irq && !irq_prev && started) begin
        chk((cyc - start_cyc) == exp_per + 2, "irq_after_start",
            cyc - start_cyc, exp_per + 2);
        started  = 0;
        irq_seen = 1;
        irq_cyc  = cyc;
      end
      irq_prev = bus0.irq;
      if (bus0.chipselect) begin
        n_wr0++;
        if (first_pend) begin
          chk((cyc - go_cyc) == 2, "go_to_first_write", cyc - go_cyc, 2);
          first_pend = 0;
        end
        if (exq.size() == 0) begin
          chk(0, "unexpected_write_addr", bus0.address, -1);
        end else begin
          e = exq.pop_front();
          chk(int'(bus0.address) == e.a, "wr_addr", bus0.address, e.a);
          chk(int'(bus0.writedata) == e.d, "wr_data", bus0.writedata, e.d);
          if (e.a == 2) exp_lo = e.d;
          if (e.a == 3) exp_per = (e.d << 16) | exp_lo;
          if (e.a == 1 && e.d == 5) begin
            started   = 1;
            start_cyc = cyc;
            n_st0++;
          end
          if (e.a == 0 && irq_seen) begin
            chk((cyc - irq_cyc) == 1, "irq_to_clear", cyc - irq_cyc, 1);
            irq_seen = 0;
          end
        end
      end
      if (evt0) begin
        n_ev0++;
        if (evq.size() == 0) begin
          chk(0, "unexpected_evt_slot", evs0, -1);
        end else begin
          es = evq.pop_front();
          chk(int'(evs0) == es, "evt_slot", evs0, es);
        end
      end
      if (done0) begin
        n_done0++;
        done_cyc = cyc;
      end
    end
  end

  // Capture for instance 1.
  wr_t w1q [$];
  int  n_st1 = 0, n_ev1 = 0, n_done1 = 0;
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus1.chipselect) begin
        w1q.push_back('{int'(bus1.address), int'(bus1.writedata)});
        if (bus1.address == 3'd1 && bus1.writedata == 16'd5) n_st1++;
      end
      if (evt1) n_ev1++;
      if (done1) n_done1++;
    end
  end

  task automatic cfg_w(input int s, input int p, input int r);
    cfg_wr = 1'b1;
    cfg_slot = 2'(s);
    cfg_period = 32'(p);
    cfg_repeat = 8'(r);
    m_per[s] = 32'(p);
    m_rep[s] = 8'(r);
    @(posedge clk); #1;
    cfg_wr = 1'b0;
  endtask

  task automatic start0();
    model_build();
    go_cyc = cyc;
    first_pend = 1;
    go0 = 1'b1;
    @(posedge clk); #1;
    go0 = 1'b0;
  endtask

  task automatic wait_done0(input int budget);
    int d0;
    d0 = n_done0;
    for (int i = 0; i < budget && n_done0 == d0; i++) @(posedge clk);
    #1;
    chk(n_done0 != d0, "done0_timeout", n_done0, d0 + 1);
  endtask

  task automatic run_end_checks(input string tag);
    chk(exq.size() == 0, {tag, "_writes_left"}, exq.size(), 0);
    chk(evq.size() == 0, {tag, "_evts_left"}, evq.size(), 0);
    chk(busy0 == 1'b0, {tag, "_busy_after_done"}, busy0, 0);
  endtask

  task automatic chk_reset0(input string tag);
    chk(busy0 == 0, {tag, "_busy"}, busy0, 0);
    chk(cur0 == 0, {tag, "_cur_slot"}, cur0, 0);
    chk(evt0 == 0, {tag, "_evt"}, evt0, 0);
    chk(evs0 == 0, {tag, "_evt_slot"}, evs0, 0);
    chk(done0 == 0, {tag, "_done"}, done0, 0);
    chk(bus0.chipselect == 0, {tag, "_cs"}, bus0.chipselect, 0);
    chk(bus0.write_n == 1, {tag, "_write_n"}, bus0.write_n, 1);
    chk(bus0.address == 0, {tag, "_addr"}, bus0.address, 0);
    chk(bus0.writedata == 0, {tag, "_wdata"}, bus0.writedata, 0);
  endtask

  int wb, eb, db;
  wr_t w1exp [$];

  initial begin
    reset_n = 1'b0;
    cfg_wr = 0; cfg_slot = 0; cfg_period = 0; cfg_repeat = 0;
    go0 = 0; abort0 = 0; go1 = 0; abort1 = 0;
    for (int s = 0; s < 4; s++) begin m_per[s] = 0; m_rep[s] = 0; end
    @(negedge clk);
    chk_reset0("rst");
    chk(busy1 == 0 && bus1.write_n == 1, "rst_inst1", busy1, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // 1: single run, period 9
    cfg_w(0, 9, 1);
    wb = n_wr0; eb = n_ev0;
    start0();
    wait_done0(200);
    run_end_checks("t1");
    chk((n_wr0 - wb) == 4, "t1_nwrites", n_wr0 - wb, 4);
    chk((n_ev0 - eb) == 1, "t1_nevts", n_ev0 - eb, 1);
    chk((done_cyc - go_cyc) == 21, "t1_go_to_done", done_cyc - go_cyc, 21);

    // 2: slot0 {3,3}, slot1 {5,2}
    cfg_w(0, 3, 3);
    cfg_w(1, 5, 2);
    wb = n_wr0; eb = n_ev0;
    start0();
    wait_done0(400);
    run_end_checks("t2");
    chk((n_wr0 - wb) == 14, "t2_nwrites", n_wr0 - wb, 14);
    chk((n_ev0 - eb) == 5, "t2_nevts", n_ev0 - eb, 5);

    // 3: all repeats 0
    cfg_w(0, 7, 0);
    cfg_w(1, 7, 0);
    wb = n_wr0;
    start0();
    wait_done0(20);
    run_end_checks("t3");
    chk((n_wr0 - wb) == 0, "t3_nwrites", n_wr0 - wb, 0);
    chk((done_cyc - go_cyc) <= 6, "t3_done_latency", done_cyc - go_cyc, 6);

    // 5: table rewrite during slot0 WAIT leaves the run intact
    cfg_w(0, 4, 2);
    wb = n_st0;
    start0();
    for (int i = 0; i < 50 && n_st0 == wb; i++) @(posedge clk);
    #1;
    chk(n_st0 != wb, "t5_start_timeout", n_st0, wb + 1);
    cfg_w(0, 20, 1);
    wait_done0(200);
    run_end_checks("t5a");
    eb = n_ev0;
    start0();
    wait_done0(200);
    run_end_checks("t5b");
    chk((n_ev0 - eb) == 1, "t5b_nevts", n_ev0 - eb, 1);

    // abort in IDLE, and go+abort together, start nothing
    wb = n_wr0; db = n_done0;
    abort0 = 1'b1;
    @(posedge clk); #1;
    go0 = 1'b1;
    @(posedge clk); #1;
    go0 = 1'b0; abort0 = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk(busy0 == 0, "idle_abort_busy", busy0, 0);
    chk((n_wr0 - wb) == 0, "idle_abort_writes", n_wr0 - wb, 0);
    chk((n_done0 - db) == 0, "idle_abort_done", n_done0 - db, 0);

    // 6: reset in WAIT, then clean restart
    cfg_w(0, 50, 1);
    wb = n_st0;
    start0();
    for (int i = 0; i < 50 && n_st0 == wb; i++) @(posedge clk);
    repeat (5) @(posedge clk);
    #1;
    chk(busy0 == 1, "t6_busy_in_wait", busy0, 1);
    reset_n = 1'b0;
    exq.delete(); evq.delete();
    started = 0; irq_seen = 0; irq_prev = 0; first_pend = 0;
    for (int s = 0; s < 4; s++) begin m_per[s] = 0; m_rep[s] = 0; end
    @(negedge clk);
    chk_reset0("t6");
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    cfg_w(0, 6, 1);
    eb = n_ev0;
    start0();
    wait_done0(200);
    run_end_checks("t6r");
    chk((n_ev0 - eb) == 1, "t6r_nevts", n_ev0 - eb, 1);

    // 4: LOOP=1, abort in WAIT on the third pass
    cfg_w(0, 4, 1);
    w1q.delete();
    go1 = 1'b1;
    @(posedge clk); #1;
    go1 = 1'b0;
    for (int i = 0; i < 300 && n_st1 < 3; i++) @(posedge clk);
    #1;
    chk(n_st1 == 3, "t4_third_start", n_st1, 3);
    @(posedge clk); #1;
    abort1 = 1'b1;
    @(posedge clk); #1;
    abort1 = 1'b0;
    for (int i = 0; i < 20 && n_done1 == 0; i++) @(posedge clk);
    #1;
    chk(n_done1 == 1, "t4_done", n_done1, 1);
    chk(busy1 == 0, "t4_busy", busy1, 0);
    chk(t_run[1] == 0, "t4_timer_run", t_run[1], 0);
    chk(n_ev1 == 2, "t4_nevts", n_ev1, 2);
    for (int p = 0; p < 3; p++) begin
      w1exp.push_back('{2, 4});
      w1exp.push_back('{3, 0});
      w1exp.push_back('{1, 5});
      if (p < 2) w1exp.push_back('{0, 0});
    end
    w1exp.push_back('{1, 8});
    w1exp.push_back('{0, 0});
    chk(w1q.size() == w1exp.size(), "t4_nwrites", w1q.size(), w1exp.size());
    for (int i = 0; i < w1exp.size() && i < w1q.size(); i++) begin
      chk(w1q[i].a == w1exp[i].a && w1q[i].d == w1exp[i].d, "t4_write",
          w1q[i].a * 65536 + w1q[i].d, w1exp[i].a * 65536 + w1exp[i].d);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=%0d expected=0", cyc);
    $fatal(1, "watchdog");
  end

endmodule
